// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: streams row-major bytes into two zero-padded DIMxDIM operand matrices
// and holds them valid until the downstream stage takes them.
module matrix_operand_loader #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [2:0]                mat_size,
  input  logic [ELEM_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DIM*DIM*ELEM_W-1:0] matrix_A,
  output logic [DIM*DIM*ELEM_W-1:0] matrix_B,
  output logic                      mats_valid,
  input  logic                      mats_ready,
  output logic                      busy,
  output logic                      load_err
);
  localparam int AW = $clog2(DIM*DIM);
  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, PRESENT} state_t;
  state_t                    state_q;
  logic [2:0]                n_q, row_q, col_q;
  logic [DIM*DIM*ELEM_W-1:0] a_q, b_q;
  logic                      valid_q, err_q;
  logic [AW-1:0]             idx;
  logic                      bad, last_col, last;
  assign idx      = AW'(32'(row_q) * DIM + 32'(col_q));
  assign bad      = mat_size < 3'd2 || mat_size > 3'(DIM);
  assign last_col = col_q == n_q - 3'd1;
  assign last     = last_col && row_q == n_q - 3'd1;
  assign in_ready = state_q == LOAD_A || state_q == LOAD_B;
  assign busy     = state_q != IDLE;
  assign matrix_A   = a_q;
  assign matrix_B   = b_q;
  assign mats_valid = valid_q;
  assign load_err   = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= 3'(DIM);
      row_q   <= '0;
      col_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          n_q     <= bad ? 3'(DIM) : mat_size;
          err_q   <= bad;
          a_q     <= '0;
          b_q     <= '0;
          row_q   <= '0;
          col_q   <= '0;
          state_q <= LOAD_A;
        end
        LOAD_A, LOAD_B: if (in_valid) begin
          if (state_q == LOAD_A) a_q[32'(idx)*ELEM_W +: ELEM_W] <= in_data;
          else b_q[32'(idx)*ELEM_W +: ELEM_W] <= in_data;
          col_q <= last_col ? 3'd0 : col_q + 3'd1;
          row_q <= last ? 3'd0 : (last_col ? row_q + 3'd1 : row_q);
          if (last) begin
            state_q <= state_q == LOAD_A ? LOAD_B : PRESENT;
            valid_q <= state_q == LOAD_B;
          end
        end
        PRESENT: if (mats_ready) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb_matrix_operand_loader: scenario tasks with a queue scoreboard of expected operand pairs.
module tb_matrix_operand_loader;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, mats_ready = 1'b0;
  logic [2:0]   mat_size = '0;
  logic [7:0]   in_data = '0;
  logic         in_ready, mats_valid, busy, load_err;
  logic [199:0] matrix_A, matrix_B;
  int           checks = 0, failures = 0, cyc;
  logic         e1, e2;
  logic [7:0]   da[50], db[50];
  logic [199:0] qa[$], qb[$], last_a, last_b;

  matrix_operand_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mat_size(mat_size), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .matrix_A(matrix_A), .matrix_B(matrix_B),
    .mats_valid(mats_valid), .mats_ready(mats_ready), .busy(busy), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    cyc++;
    if (cyc == 1) e2 = load_err;
  endtask

  // Drives a start then lim beats; only complete loads enter the scoreboard.
  task automatic run_load(input logic [2:0] sz, input int n, input int lim, input bit gaps);
    logic [199:0] ea = '0, eb = '0;
    int idx, t;
    for (int i = 0; i < n*n; i++) begin
      idx = (i / n) * 5 + i % n;
      ea[idx*8 +: 8] = da[i];
      eb[idx*8 +: 8] = db[i];
    end
    if (lim == 2*n*n) begin
      qa.push_back(ea);
      qb.push_back(eb);
    end
    @(negedge clk);
    start = 1'b1;
    mat_size = sz;
    cyc = -1;
    step();
    start = 1'b0;
    e1 = load_err;
    for (int i = 0; i < lim; i++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data = 8'($urandom);
        step();
      end
      in_valid = 1'b1;
      in_data = i < n*n ? da[i] : db[i-n*n];
      checks++;
      if (mats_valid !== 1'b0 || busy !== 1'b1)
        begin failures++; $display("FAIL load_busy beat=%0d mats_valid=%b busy=%b want 0/1", i, mats_valid, busy); end
      t = 0;
      while (!in_ready && t < 50) begin step(); t++; end
      checks++;
      if (in_ready !== 1'b1)
        begin failures++; $display("FAIL in_ready_timeout beat=%0d in_ready=%b want 1", i, in_ready); end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_present(input string name);
    int t = 0;
    while (mats_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (mats_valid !== 1'b1) begin failures++; $display("FAIL %s_valid mats_valid=%b want 1", name, mats_valid); end
    checks++;
    if (qa.size() == 0) begin failures++; $display("FAIL %s_sb queue empty want entry", name); end
    else begin
      last_a = qa.pop_front();
      last_b = qb.pop_front();
      if (matrix_A !== last_a) begin failures++; $display("FAIL %s_A got=%h want=%h", name, matrix_A, last_a); end
      checks++;
      if (matrix_B !== last_b) begin failures++; $display("FAIL %s_B got=%h want=%h", name, matrix_B, last_b); end
    end
  endtask

  task automatic release_mats(input string name);
    mats_ready = 1'b1;
    @(negedge clk);
    mats_ready = 1'b0;
    checks++;
    if (mats_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0)
      begin failures++; $display("FAIL %s_handoff valid=%b busy=%b in_ready=%b want 0/0/0", name, mats_valid, busy, in_ready); end
    checks++;
    if (matrix_A !== last_a || matrix_B !== last_b)
      begin failures++; $display("FAIL %s_retain A=%h B=%h want A=%h B=%h", name, matrix_A, matrix_B, last_a, last_b); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, busy, mats_valid, load_err} !== 4'b0 || matrix_A !== '0 || matrix_B !== '0)
        begin failures++; $display("FAIL reset_idle cyc=%0d rdy/busy/valid/err=%b%b%b%b want 0000", i, in_ready, busy, mats_valid, load_err); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_load5();
    for (int i = 0; i < 25; i++) begin da[i] = 8'(i); db[i] = 8'(8'h80 + i); end
    run_load(3'd5, 5, 50, 1'b0);
    checks++;
    if (cyc != 50) begin failures++; $display("FAIL load5_latency got=%0d want=50", cyc); end
    checks++;
    if (e1 !== 1'b0) begin failures++; $display("FAIL load5_err got=%b want 0", e1); end
    check_present("load5");
    checks++;
    if (matrix_A[24*8 +: 8] !== 8'h18 || matrix_B[7:0] !== 8'h80)
      begin failures++; $display("FAIL load5_bytes A24=%h B0=%h want 18/80", matrix_A[24*8 +: 8], matrix_B[7:0]); end
    release_mats("load5");
  endtask

  task automatic test_load3();
    for (int i = 0; i < 9; i++) begin da[i] = 8'(i + 1); db[i] = 8'(8'hF1 + i); end
    run_load(3'd3, 3, 18, 1'b0);
    checks++;
    if (cyc != 18) begin failures++; $display("FAIL load3_latency got=%0d want=18", cyc); end
    check_present("load3");
    checks++;
    if (matrix_A[23:0] !== 24'h030201 || matrix_A[47:40] !== 8'h04 || matrix_A[103:96] !== 8'h09)
      begin failures++; $display("FAIL load3_bytes A=%h want bytes0-2=01,02,03 b5=04 b12=09", matrix_A); end
    checks++;
    if (matrix_A[39:24] !== 16'h0 || matrix_A[199:104] !== 96'h0 || matrix_B[199:104] !== 96'h0)
      begin failures++; $display("FAIL load3_pad A=%h B=%h want zero outside 3x3", matrix_A, matrix_B); end
  endtask

  task automatic test_present_hold();
    for (int i = 0; i < 10; i++) begin
      mats_ready = 1'b0;
      in_valid = ~in_valid;
      start = ~start;
      mat_size = 3'd2;
      in_data = 8'($urandom);
      @(negedge clk);
      checks++;
      if (mats_valid !== 1'b1 || load_err !== 1'b0 || in_ready !== 1'b0 || matrix_A !== last_a || matrix_B !== last_b)
        begin failures++; $display("FAIL hold cyc=%0d valid=%b err=%b rdy=%b A=%h want 1/0/0 A=%h", i, mats_valid, load_err, in_ready, matrix_A, last_a); end
    end
    start = 1'b0;
    in_valid = 1'b0;
    release_mats("hold");
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || load_err !== 1'b0) begin failures++; $display("FAIL hold_idle busy=%b err=%b want 0/0", busy, load_err); end
  endtask

  task automatic test_bad_size();
    for (int i = 0; i < 25; i++) begin da[i] = 8'($urandom); db[i] = 8'($urandom); end
    run_load(3'd0, 5, 50, 1'b1);
    checks++;
    if (e1 !== 1'b1 || e2 !== 1'b0) begin failures++; $display("FAIL bad_err pulse=%b%b want 10", e1, e2); end
    checks++;
    if (cyc < 50) begin failures++; $display("FAIL bad_latency got=%0d want>=50", cyc); end
    check_present("bad");
    release_mats("bad");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 9; i++) begin da[i] = 8'(8'h10 + i); db[i] = 8'(8'h20 + i); end
    run_load(3'd3, 3, 16, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, mats_valid, load_err} !== 4'b0 || matrix_A !== '0 || matrix_B !== '0)
      begin failures++; $display("FAIL midreset rdy/busy/valid/err=%b%b%b%b A=%h want all 0", in_ready, busy, mats_valid, load_err, matrix_A); end
    @(negedge clk);
    rst_n = 1'b1;
    da[0] = 8'h11; da[1] = 8'h22; da[2] = 8'h33; da[3] = 8'h44;
    db[0] = 8'hFF; db[1] = 8'hFE; db[2] = 8'hFD; db[3] = 8'h80;
    run_load(3'd2, 2, 8, 1'b0);
    checks++;
    if (cyc != 8) begin failures++; $display("FAIL fresh2_latency got=%0d want=8", cyc); end
    check_present("fresh2");
    release_mats("fresh2");
  endtask

  initial begin
    test_reset();
    test_load5();
    test_load3();
    test_present_hold();
    test_bad_size();
    test_back_to_back();
    checks++;
    if (qa.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d want=0", qa.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
